// File: rtl/qed_dup_replay.sv
// qed_dup_replay: Symbolic-QED duplication stage between constrained fetch and the decoder.
// ORIG passes instructions through with zero latency and records each one. After exec_dup, the
// recorded instructions are replayed with registers moved to x16-x31 and memory offsets moved
// up by 64 bytes. DONE is terminal until rst.
// Optional build macro: QED_DONE_NOP_EN -- in DONE, drive a continuous stream of QED NOPs
// (32'h0000007F) instead of going idle.
module qed_dup_replay #(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [31:0]      in_instr,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             exec_dup,
   output logic [31:0]      out_instr,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             sif_commit,
   output logic             qed_ready,
   output logic [CNT_W-1:0] orig_cnt,
   output logic [CNT_W-1:0] dup_cnt,
   output logic             buf_full
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PTR_W:0] OCC_FULL = (PTR_W + 1)'(DEPTH);

   typedef enum logic [1:0] {StOrig, StDup, StDone} state_e;

   state_e             state_q, state_d;
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]     occ_q, occ_d;
   logic [PTR_W:0]     occ_post;
   logic [CNT_W-1:0]   orig_cnt_q, orig_cnt_d;
   logic [CNT_W-1:0]   dup_cnt_q, dup_cnt_d;
   logic               sif_commit_q, sif_commit_d;
   logic               qed_ready_q, qed_ready_d;
   logic               push, pop;
   logic [31:0]        mem_q [DEPTH];

   // Register fields move to the upper half; x0 stays x0 so it remains hardwired zero.
   function automatic logic [4:0] map_reg(input logic [4:0] r);
      return (r == 5'd0) ? 5'd0 : (r | 5'b10000);
   endfunction

   // Upstream guarantees fields < 16 and offsets < 64, so OR-ing bits is equivalent to adding.
   function automatic logic [31:0] remap(input logic [31:0] i);
      logic [31:0] o;
      o = i;
      case (i[6:0])
         7'b0110011: begin
            o[11:7]  = map_reg(i[11:7]);
            o[19:15] = map_reg(i[19:15]);
            o[24:20] = map_reg(i[24:20]);
         end
         7'b0010011, 7'b1100111: begin
            o[11:7]  = map_reg(i[11:7]);
            o[19:15] = map_reg(i[19:15]);
         end
         7'b0000011: begin
            o[11:7]  = map_reg(i[11:7]);
            o[19:15] = map_reg(i[19:15]);
            o[26]    = 1'b1;
         end
         7'b0100011: begin
            o[19:15] = map_reg(i[19:15]);
            o[24:20] = map_reg(i[24:20]);
            o[26]    = 1'b1;
         end
         7'b1100011: begin
            o[19:15] = map_reg(i[19:15]);
            o[24:20] = map_reg(i[24:20]);
         end
         7'b0110111, 7'b0010111, 7'b1101111: begin
            o[11:7]  = map_reg(i[11:7]);
         end
         default: o = i;
      endcase
      return o;
   endfunction

   assign buf_full = (occ_q == OCC_FULL);

   // Handshake, phase sequencing, buffer bookkeeping and counter next-state.
   always_comb begin
      state_d      = state_q;
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      occ_d        = occ_q;
      orig_cnt_d   = orig_cnt_q;
      dup_cnt_d    = dup_cnt_q;
      sif_commit_d = sif_commit_q;
      qed_ready_d  = (state_q != StOrig) && (orig_cnt_q == dup_cnt_q) && (orig_cnt_q != '0);
      in_ready     = 1'b0;
      out_valid    = 1'b0;
      out_instr    = 32'h0;
      push         = 1'b0;
      pop          = 1'b0;
      occ_post     = occ_q;

      unique case (state_q)
         StOrig: begin
            out_instr = in_instr;
            out_valid = in_valid & ~buf_full;
            in_ready  = out_ready & ~buf_full;
            push      = in_valid & in_ready;
            occ_post  = occ_q + (PTR_W + 1)'(push);
            // A same-cycle accepted instruction is counted, so it joins the replay.
            if (exec_dup && (occ_post != '0)) begin
               state_d      = StDup;
               sif_commit_d = 1'b1;
            end
         end
         StDup: begin
            out_valid = (occ_q != '0);
            out_instr = remap(mem_q[rd_ptr_q]);
            pop       = out_valid & out_ready;
            if (pop && (occ_q == (PTR_W + 1)'(1))) begin
               state_d = StDone;
            end
         end
         StDone: begin
`ifdef QED_DONE_NOP_EN
            out_valid = 1'b1;
            out_instr = 32'h0000007F;
`else
            out_valid = 1'b0;
            out_instr = 32'h0;
`endif
         end
         default: state_d = StOrig;
      endcase

      if (push) begin
         wr_ptr_d   = wr_ptr_q + 1'b1;
         occ_d      = occ_q + (PTR_W + 1)'(1);
         orig_cnt_d = (orig_cnt_q == '1) ? orig_cnt_q : orig_cnt_q + CNT_W'(1);
      end
      if (pop) begin
         rd_ptr_d   = rd_ptr_q + 1'b1;
         occ_d      = occ_q - (PTR_W + 1)'(1);
         dup_cnt_d  = (dup_cnt_q == '1) ? dup_cnt_q : dup_cnt_q + CNT_W'(1);
      end
   end

   // Control state with synchronous reset; reset discards buffer contents via the pointers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= StOrig;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         occ_q        <= '0;
         orig_cnt_q   <= '0;
         dup_cnt_q    <= '0;
         sif_commit_q <= 1'b0;
         qed_ready_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         occ_q        <= occ_d;
         orig_cnt_q   <= orig_cnt_d;
         dup_cnt_q    <= dup_cnt_d;
         sif_commit_q <= sif_commit_d;
         qed_ready_q  <= qed_ready_d;
      end
   end

   // Replay storage; no reset needed since occupancy gates every read.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= in_instr;
      end
   end

   assign sif_commit = sif_commit_q;
   assign qed_ready  = qed_ready_q;
   assign orig_cnt   = orig_cnt_q;
   assign dup_cnt    = dup_cnt_q;

endmodule

// File: tb/tb_qed_dup_replay.sv
// tb_qed_dup_replay: scoreboard bench for qed_dup_replay (default build, NOP macro undefined).
// Stimulus pushes expected output instructions; a negedge monitor pops them on each handshake.
`timescale 1ns/1ps
module tb_qed_dup_replay;

   localparam int DEPTH = 16;
   localparam int CNT_W = 16;

   logic             clk = 1'b0;
   logic             rst;
   logic [31:0]      in_instr;
   logic             in_valid;
   logic             in_ready;
   logic             exec_dup;
   logic [31:0]      out_instr;
   logic             out_valid;
   logic             out_ready;
   logic             sif_commit;
   logic             qed_ready;
   logic [CNT_W-1:0] orig_cnt;
   logic [CNT_W-1:0] dup_cnt;
   logic             buf_full;

   int errors = 0;
   int checks = 0;
   logic [31:0] exp_q[$];
   logic [31:0] vin  [8];
   logic [31:0] vdup [8];

   qed_dup_replay #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_instr   (in_instr),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .exec_dup   (exec_dup),
      .out_instr  (out_instr),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .sif_commit (sif_commit),
      .qed_ready  (qed_ready),
      .orig_cnt   (orig_cnt),
      .dup_cnt    (dup_cnt),
      .buf_full   (buf_full)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: every accepted output must match the next scoreboard entry.
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL out_unexpected: got %h expected none", out_instr);
         end else begin
            chk("out_instr", out_instr, exp_q.pop_front());
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; in_valid = 1'b0; exec_dup = 1'b0; out_ready = 1'b1; in_instr = 32'h0;
      step();
      rst = 1'b0;
      exp_q.delete();
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

   initial begin
      int k;
      // Hand-computed original/duplicate pairs.
      vin[0] = 32'h00208033; vdup[0] = 32'h01288033; // add x0,x1,x2  -> add x0,x17,x18
      vin[1] = 32'h002081B3; vdup[1] = 32'h012889B3; // add x3,x1,x2  -> add x19,x17,x18
      vin[2] = 32'h00402083; vdup[2] = 32'h04402883; // lw x1,4(x0)   -> lw x17,68(x0)
      vin[3] = 32'h00302223; vdup[3] = 32'h05302223; // sw x3,4(x0)   -> sw x19,68(x0)
      vin[4] = 32'h0000007F; vdup[4] = 32'h0000007F; // QED NOP unchanged
      vin[5] = 32'h00730293; vdup[5] = 32'h007B0A93; // addi x5,x6,7  -> addi x21,x22,7
      vin[6] = 32'h00208063; vdup[6] = 32'h01288063; // beq x1,x2,0   -> beq x17,x18,0
      vin[7] = 32'h123453B7; vdup[7] = 32'h12345BB7; // lui x7,0x12345 -> lui x23

      step();
      do_reset();
      @(negedge clk);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_sif_commit", sif_commit, 0);
      chk("rst_qed_ready", qed_ready, 0);
      chk("rst_orig_cnt", orig_cnt, 0);
      chk("rst_dup_cnt", dup_cnt, 0);
      chk("rst_buf_full", buf_full, 0);

      // exec_dup on an empty buffer is ignored.
      step(); exec_dup = 1'b1;
      step(); exec_dup = 1'b0;
      @(negedge clk);
      chk("empty_dup_sif", sif_commit, 0);
      chk("empty_dup_in_ready", in_ready, 1);

      // Zero-latency pass-through.
      step(); in_valid = 1'b1; in_instr = vin[0]; exp_q.push_back(vin[0]);
      @(negedge clk);
      chk("pass_out_valid", out_valid, 1);
      step(); in_valid = 1'b0;
      @(negedge clk);
      chk("pass_orig_cnt", orig_cnt, 1);
      chk("pass_sif", sif_commit, 0);

      // Single original then replay.
      step(); do_reset();
      in_valid = 1'b1; in_instr = vin[1]; exp_q.push_back(vin[1]);
      step(); in_valid = 1'b0; exec_dup = 1'b1; exp_q.push_back(vdup[1]);
      step(); exec_dup = 1'b0;
      @(negedge clk);
      chk("dup1_sif", sif_commit, 1);
      chk("dup1_out_valid", out_valid, 1);
      step();
      @(negedge clk);
      chk("dup1_dup_cnt", dup_cnt, 1);
      chk("dup1_done_idle", out_valid, 0);
      step();
      @(negedge clk);
      chk("dup1_qed_ready", qed_ready, 1);

      // exec_dup coincident with an accepted instruction; backpressure during DUP.
      step(); do_reset();
      in_valid = 1'b1; in_instr = vin[2]; exp_q.push_back(vin[2]);
      step(); in_instr = vin[3]; exec_dup = 1'b1;
      exp_q.push_back(vin[3]); exp_q.push_back(vdup[2]); exp_q.push_back(vdup[3]);
      step(); in_valid = 1'b0; exec_dup = 1'b0; out_ready = 1'b0;
      @(negedge clk);
      chk("co_stall_valid", out_valid, 1);
      chk("co_in_ready", in_ready, 0);
      step(); out_ready = 1'b1;
      step(); step();
      @(negedge clk);
      chk("co_orig_cnt", orig_cnt, 2);
      chk("co_dup_cnt", dup_cnt, 2);
      chk("co_done_idle", out_valid, 0);
      step();
      @(negedge clk);
      chk("co_qed_ready", qed_ready, 1);

      // Reset asserted mid-DUP.
      step(); do_reset();
      in_valid = 1'b1; in_instr = vin[4]; exp_q.push_back(vin[4]);
      step(); in_instr = vin[5]; exp_q.push_back(vin[5]);
      step(); in_valid = 1'b0; exec_dup = 1'b1;
      step(); exec_dup = 1'b0; out_ready = 1'b0;
      @(negedge clk);
      chk("mid_sif_before", sif_commit, 1);
      step(); rst = 1'b1;
      step(); rst = 1'b0; out_ready = 1'b1; exp_q.delete();
      @(negedge clk);
      chk("mid_sif", sif_commit, 0);
      chk("mid_orig_cnt", orig_cnt, 0);
      chk("mid_dup_cnt", dup_cnt, 0);
      chk("mid_qed_ready", qed_ready, 0);
      chk("mid_buf_full", buf_full, 0);
      chk("mid_out_valid", out_valid, 0);
      chk("mid_in_ready", in_ready, 1);

      // Fill the buffer, try a 17th, then replay all 16.
      step(); do_reset();
      for (int i = 0; i < DEPTH; i++) begin
         in_valid = 1'b1; in_instr = vin[i % 8]; exp_q.push_back(vin[i % 8]);
         step();
      end
      in_instr = 32'hDEADBEEF;
      @(negedge clk);
      chk("full_buf_full", buf_full, 1);
      chk("full_in_ready", in_ready, 0);
      chk("full_out_valid", out_valid, 0);
      chk("full_orig_cnt", orig_cnt, 16);
      step(); exec_dup = 1'b1;
      for (int i = 0; i < DEPTH; i++) exp_q.push_back(vdup[i % 8]);
      step(); exec_dup = 1'b0; in_valid = 1'b0;
      k = 0;
      while (out_valid && k < 50) begin
         step();
         k++;
      end
      chk("full_drain_bound", (k < 50), 1);
      @(negedge clk);
      chk("full_orig_final", orig_cnt, 16);
      chk("full_dup_final", dup_cnt, 16);
      chk("full_done_idle", out_valid, 0);
      chk("full_buf_empty", buf_full, 0);
      chk("full_sif_held", sif_commit, 1);
      step();
      @(negedge clk);
      chk("full_qed_ready", qed_ready, 1);
      chk("scoreboard_empty", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
